// File: rtl/odd_pipe_pkg.sv
// Shared types and constants for the odd execution pipe: opcodes, writeback record layout, unit ids.
// Optional gather support is enabled by defining ODD_PIPE_GATHER_EN.
package odd_pipe_pkg;

    localparam int unsigned LATENCY = 4;
    localparam int unsigned LS_AW   = 15;
    localparam int unsigned QW      = 128;
    localparam int unsigned REC_W   = 143;

    // out_op field offsets, counted from the MSB (bit 0 = MSB)
    localparam int unsigned OFF_RT   = 0;
    localparam int unsigned OFF_ADDR = 128;
    localparam int unsigned OFF_WEN  = 135;
    localparam int unsigned OFF_UNIT = 136;
    localparam int unsigned OFF_LAT  = 139;

    localparam logic [2:0] UNIT_NONE = 3'd0;
    localparam logic [2:0] UNIT_PERM = 3'd1;
    localparam logic [2:0] UNIT_LS   = 3'd2;
    localparam logic [2:0] UNIT_BR   = 3'd3;

    localparam logic [31:0]      PC_MASK    = 32'hFFFF_FFFC;
    localparam logic [LS_AW-1:0] LS_QW_MASK = 15'h7FF0;

    typedef enum logic [4:0] {
        NOP                                             = 5'd0,
        SHIFT_LEFT_QUADWORD_BY_BITS                     = 5'd1,
        SHIFT_LEFT_QUADWORD_BY_BITS_IMMEDIATE           = 5'd2,
        SHIFT_LEFT_QUADWORD_BY_BYTES                    = 5'd3,
        SHIFT_LEFT_QUADWORD_BY_BYTE_IMMEDIATE           = 5'd4,
        SHIFT_LEFT_QUADWORD_BY_BYTES_FROM_BIT_SHIFT_COUNT = 5'd5,
        ROTATE_QUADWORD_BY_BYTES                        = 5'd6,
        ROTATE_QUADWORD_BY_BYTES_IMMEDIATE              = 5'd7,
        ROTATE_QUADWORD_BY_BYTES_FROM_BIT_SHIFT_COUNT   = 5'd8,
        ROTATE_QUADWORD_BY_BITS                         = 5'd9,
        ROTATE_QUADWORD_BY_BITS_IMMEDIATE               = 5'd10,
        GATHER_BITS_FROM_BYTES                          = 5'd11,
        GATHER_BITS_FROM_HALFWORDS                      = 5'd12,
        GATHER_BITS_FROM_WORDS                          = 5'd13,
        LOAD_QUADWORD_D_FORM                            = 5'd14,
        LOAD_QUADWORD_A_FORM                            = 5'd15,
        STORE_QUADWORD_D_FORM                           = 5'd16,
        STORE_QUADWORD_A_FORM                           = 5'd17,
        BRANCH_RELATIVE                                 = 5'd18,
        BRANCH_ABSOLUTE                                 = 5'd19,
        BRANCH_RELATIVE_AND_SET_LINK                    = 5'd20,
        BRANCH_IF_ZERO_WORD                             = 5'd21,
        BRANCH_IF_NOT_ZERO_WORD                         = 5'd22
    } op_code_e;

    typedef struct packed {
        logic [QW-1:0] rt_value;
        logic [6:0]    rt_addr;
        logic          wr_en;
        logic [2:0]    unit;
        logic [3:0]    latency;
    } rec_t;

    // Quadword rotate left; a zero count yields v because v >> 128 is 0.
    function automatic logic [QW-1:0] rotl_qw(input logic [QW-1:0] v, input logic [6:0] n);
        logic [7:0] rn;
        rn = 8'd128 - {1'b0, n};
        return (v << n) | (v >> rn);
    endfunction

endpackage

// File: rtl/odd_pipe_permute_unit.sv
// Combinational quadword shift / rotate / gather datapath of the odd pipe.
// Gather ops exist only when ODD_PIPE_GATHER_EN is defined; otherwise hit_c stays low for them.
module odd_permute_unit
    import odd_pipe_pkg::*;
(
    input  logic [QW-1:0] ra,
    input  logic [QW-1:0] rb,
    input  logic [6:0]    i7,
    input  op_code_e      op_code,
    output logic [QW-1:0] result_c,
    output logic          hit_c
);

    // Counts come from rb word 0, i.e. vector bits [127:96]; MSB-0 bit k maps to 127-k.
    logic unused_bits;
    assign unused_bits = ^{rb[127:104], rb[95:0], i7[6:5]};

    always_comb begin
        result_c = '0;
        hit_c    = 1'b1;
        case (op_code)
            SHIFT_LEFT_QUADWORD_BY_BITS:            result_c = ra << rb[98:96];
            SHIFT_LEFT_QUADWORD_BY_BITS_IMMEDIATE:  result_c = ra << i7[2:0];
            // Byte shifts of 16 or more move every bit out, giving zero.
            SHIFT_LEFT_QUADWORD_BY_BYTES:           result_c = ra << {rb[100:96], 3'b000};
            SHIFT_LEFT_QUADWORD_BY_BYTE_IMMEDIATE:  result_c = ra << {i7[4:0], 3'b000};
            SHIFT_LEFT_QUADWORD_BY_BYTES_FROM_BIT_SHIFT_COUNT:
                                                    result_c = ra << {rb[103:99], 3'b000};
            ROTATE_QUADWORD_BY_BYTES:               result_c = rotl_qw(ra, {rb[99:96], 3'b000});
            ROTATE_QUADWORD_BY_BYTES_IMMEDIATE:     result_c = rotl_qw(ra, {i7[3:0], 3'b000});
            ROTATE_QUADWORD_BY_BYTES_FROM_BIT_SHIFT_COUNT:
                                                    result_c = rotl_qw(ra, {rb[102:99], 3'b000});
            ROTATE_QUADWORD_BY_BITS:                result_c = rotl_qw(ra, {4'b0000, rb[98:96]});
            ROTATE_QUADWORD_BY_BITS_IMMEDIATE:      result_c = rotl_qw(ra, {4'b0000, i7[2:0]});
`ifdef ODD_PIPE_GATHER_EN
            // LSB of each element lands in the low-order bits of rt word 0, element 0 first.
            GATHER_BITS_FROM_BYTES: begin
                for (int i = 0; i < 16; i++) result_c[111-i] = ra[120-8*i];
            end
            GATHER_BITS_FROM_HALFWORDS: begin
                for (int i = 0; i < 8; i++) result_c[103-i] = ra[112-16*i];
            end
            GATHER_BITS_FROM_WORDS: begin
                for (int i = 0; i < 4; i++) result_c[99-i] = ra[96-32*i];
            end
`endif
            default: hit_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/odd_pipe.sv
// Odd execution pipe: permute, local-store and branch ops with a fixed 4-stage writeback record.
// Define ODD_PIPE_GATHER_EN to include the gather-bits ops (handled in odd_permute_unit).
module odd_pipe
    import odd_pipe_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  op_code_e          op_input_op_code,
    input  logic [6:0]        I7_input,
    input  logic [9:0]        I10_input,
    input  logic [15:0]       I16_input,
    input  logic [17:0]       I18_input,
    input  logic [QW-1:0]     ra_input,
    input  logic [QW-1:0]     rb_input,
    input  logic [QW-1:0]     rc_input,
    input  logic [6:0]        rt_address_input,
    input  logic [31:0]       PC_input,
    output logic [31:0]       PC_output,
    output logic [LS_AW-1:0]  LS_address_output,
    input  logic [QW-1:0]     LS_data_input,
    output logic [QW-1:0]     LS_data_output,
    output logic              LS_wrt_en,
    output logic [REC_W-1:0]  out_op
);

    logic unused_i18;
    assign unused_i18 = ^I18_input;

    rec_t             s1_d, s1_q, s2_d, s2_q, s3_d, s3_q, s4_d, s4_q;
    logic             s1_load_d, s1_load_q;
    logic [31:0]      pc_d, pc_q;
    logic [LS_AW-1:0] ls_addr_d, ls_addr_q;
    logic [QW-1:0]    ls_data_d, ls_data_q;
    logic             ls_wen_d, ls_wen_q;

    logic [QW-1:0]    perm_result;
    logic             perm_hit;

    odd_permute_unit u_permute (
        .ra       (ra_input),
        .rb       (rb_input),
        .i7       (I7_input),
        .op_code  (op_input_op_code),
        .result_c (perm_result),
        .hit_c    (perm_hit)
    );

    // Effective addresses and branch targets
    logic [31:0]      br_off, br_rel, d_ea, a_ea;
    logic [LS_AW-1:0] d_addr, a_addr;
    logic             rc_w0_zero;

    assign br_off     = {{14{I16_input[15]}}, I16_input, 2'b00};
    assign br_rel     = PC_input + br_off;
    assign d_ea       = ra_input[127:96] + {{18{I10_input[9]}}, I10_input, 4'b0000};
    assign a_ea       = br_off;
    assign d_addr     = LS_AW'(d_ea) & LS_QW_MASK;
    assign a_addr     = LS_AW'(a_ea) & LS_QW_MASK;
    assign rc_w0_zero = (rc_input[127:96] == 32'd0);

    // Issue-stage decode into S1 plus LS / PC side outputs
    always_comb begin
        s1_d         = '0;
        s1_d.latency = 4'(LATENCY);
        s1_load_d    = 1'b0;
        pc_d         = (PC_input + 32'd4) & PC_MASK;
        ls_addr_d    = ls_addr_q;
        ls_data_d    = ls_data_q;
        ls_wen_d     = 1'b0;

        if (perm_hit) begin
            s1_d.rt_value = perm_result;
            s1_d.rt_addr  = rt_address_input;
            s1_d.wr_en    = 1'b1;
            s1_d.unit     = UNIT_PERM;
        end else begin
            case (op_input_op_code)
                LOAD_QUADWORD_D_FORM, LOAD_QUADWORD_A_FORM: begin
                    ls_addr_d    = (op_input_op_code == LOAD_QUADWORD_D_FORM) ? d_addr : a_addr;
                    s1_load_d    = 1'b1;
                    s1_d.rt_addr = rt_address_input;
                    s1_d.wr_en   = 1'b1;
                    s1_d.unit    = UNIT_LS;
                end
                STORE_QUADWORD_D_FORM, STORE_QUADWORD_A_FORM: begin
                    ls_addr_d    = (op_input_op_code == STORE_QUADWORD_D_FORM) ? d_addr : a_addr;
                    ls_data_d    = rc_input;
                    ls_wen_d     = 1'b1;
                    s1_d.rt_addr = rt_address_input;
                    s1_d.unit    = UNIT_LS;
                end
                BRANCH_RELATIVE, BRANCH_ABSOLUTE, BRANCH_RELATIVE_AND_SET_LINK,
                BRANCH_IF_ZERO_WORD, BRANCH_IF_NOT_ZERO_WORD: begin
                    s1_d.rt_addr = rt_address_input;
                    s1_d.unit    = UNIT_BR;
                    case (op_input_op_code)
                        BRANCH_ABSOLUTE: pc_d = br_off & PC_MASK;
                        BRANCH_IF_ZERO_WORD: begin
                            if (rc_w0_zero) pc_d = br_rel & PC_MASK;
                        end
                        BRANCH_IF_NOT_ZERO_WORD: begin
                            if (!rc_w0_zero) pc_d = br_rel & PC_MASK;
                        end
                        BRANCH_RELATIVE_AND_SET_LINK: begin
                            pc_d          = br_rel & PC_MASK;
                            s1_d.rt_value = {PC_input + 32'd4, 96'd0};
                            s1_d.wr_en    = 1'b1;
                        end
                        default: pc_d = br_rel & PC_MASK;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Load data arrives one cycle after the address and is merged into S2
    always_comb begin
        s2_d = s1_q;
        if (s1_load_q) s2_d.rt_value = LS_data_input;
        s3_d = s2_q;
        s4_d = s3_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q      <= '0;
            s2_q      <= '0;
            s3_q      <= '0;
            s4_q      <= '0;
            s1_load_q <= 1'b0;
            pc_q      <= '0;
            ls_addr_q <= '0;
            ls_data_q <= '0;
            ls_wen_q  <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            s3_q      <= s3_d;
            s4_q      <= s4_d;
            s1_load_q <= s1_load_d;
            pc_q      <= pc_d;
            ls_addr_q <= ls_addr_d;
            ls_data_q <= ls_data_d;
            ls_wen_q  <= ls_wen_d;
        end
    end

    assign PC_output         = pc_q;
    assign LS_address_output = ls_addr_q;
    assign LS_data_output    = ls_data_q;
    assign LS_wrt_en         = ls_wen_q;

    assign out_op[REC_W-1-OFF_RT   -: QW] = s4_q.rt_value;
    assign out_op[REC_W-1-OFF_ADDR -: 7]  = s4_q.rt_addr;
    assign out_op[REC_W-1-OFF_WEN]        = s4_q.wr_en;
    assign out_op[REC_W-1-OFF_UNIT -: 3]  = s4_q.unit;
    assign out_op[REC_W-1-OFF_LAT  -: 4]  = s4_q.latency;

endmodule

// File: tb/tb_odd_pipe.sv
// Directed scoreboard bench for odd_pipe: expected records are queued at issue and
// compared when they leave the 4-stage pipe; side outputs are checked one edge after issue.
module tb_odd_pipe;
    import odd_pipe_pkg::*;

    logic         clock = 1'b0;
    logic         reset;
    op_code_e     op;
    logic [6:0]   i7;
    logic [9:0]   i10;
    logic [15:0]  i16;
    logic [17:0]  i18;
    logic [127:0] ra, rb, rc, ls_din;
    logic [6:0]   rt_addr;
    logic [31:0]  pc_in;
    logic [31:0]  pc_out;
    logic [14:0]  ls_addr;
    logic [127:0] ls_dout;
    logic         ls_wen;
    logic [142:0] out_op;

    int n_checks = 0;
    int n_errors = 0;
    logic [142:0] exp_q[$];
    string        tag_q[$];

    localparam logic [127:0] LS_X = 128'hDEADBEEF_01234567_89ABCDEF_FEEDF00D;
    localparam logic [6:0]   RT   = 7'd9;

    odd_pipe dut (
        .clock             (clock),
        .reset             (reset),
        .op_input_op_code  (op),
        .I7_input          (i7),
        .I10_input         (i10),
        .I16_input         (i16),
        .I18_input         (i18),
        .ra_input          (ra),
        .rb_input          (rb),
        .rc_input          (rc),
        .rt_address_input  (rt_addr),
        .PC_input          (pc_in),
        .PC_output         (pc_out),
        .LS_address_output (ls_addr),
        .LS_data_input     (ls_din),
        .LS_data_output    (ls_dout),
        .LS_wrt_en         (ls_wen),
        .out_op            (out_op)
    );

    always #5 clock = ~clock;

    function automatic logic [127:0] w0(input logic [31:0] v);
        return {v, 96'd0};
    endfunction

    task automatic chk(input string tag, input logic [142:0] got, input logic [142:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic prefill();
        exp_q.delete();
        tag_q.delete();
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('0);
            tag_q.push_back("post_reset_zero");
        end
    endtask

    // Issue one op, advance one edge, check side outputs and the record leaving the pipe.
    task automatic step(input op_code_e o, input logic [127:0] a, input logic [127:0] b,
                        input logic [127:0] c, input logic [6:0] imm7, input logic [9:0] imm10,
                        input logic [15:0] imm16, input logic [31:0] pc,
                        input logic [127:0] exp_rt, input logic exp_wr, input logic [2:0] exp_unit,
                        input logic [31:0] exp_pc, input string tag);
        logic [6:0] ea;
        logic       exp_wen;
        op = o; ra = a; rb = b; rc = c; i7 = imm7; i10 = imm10; i16 = imm16;
        pc_in = pc; rt_addr = RT; i18 = 18'h2A5A5;
        ea = (exp_unit == 3'd0) ? 7'd0 : RT;
        exp_wen = (o == STORE_QUADWORD_D_FORM) || (o == STORE_QUADWORD_A_FORM);
        exp_q.push_back({exp_rt, ea, exp_wr, exp_unit, 4'd4});
        tag_q.push_back(tag);
        @(posedge clock);
        #1;
        chk({tag, "_pc"}, 143'(pc_out), 143'(exp_pc));
        chk({tag, "_wen"}, 143'(ls_wen), 143'(exp_wen));
        chk({tag_q.pop_front(), "_out"}, out_op, exp_q.pop_front());
    endtask

    initial begin
        logic [127:0] g_b, g_h, g_w;
        logic         g_wr;
        logic [2:0]   g_u;

        reset = 1'b1; op = NOP; ra = '0; rb = '0; rc = '0; i7 = '0; i10 = '0; i16 = '0;
        i18 = '0; pc_in = '0; rt_addr = '0; ls_din = LS_X;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_out", out_op, '0);
        chk("rst_pc", 143'(pc_out), '0);
        chk("rst_addr", 143'(ls_addr), '0);
        chk("rst_data", 143'(ls_dout), '0);
        chk("rst_wen", 143'(ls_wen), '0);
        reset = 1'b0;
        prefill();

        // permute class
        step(SHIFT_LEFT_QUADWORD_BY_BITS, 128'd20, w0(32'd10), '0, '0, '0, '0, 32'h0,
             128'd80, 1'b1, 3'd1, 32'h4, "shlqbi");
        step(SHIFT_LEFT_QUADWORD_BY_BITS_IMMEDIATE, 128'd15, '0, '0, 7'd5, '0, '0, 32'h0,
             128'd480, 1'b1, 3'd1, 32'h4, "shlqbii");
        step(SHIFT_LEFT_QUADWORD_BY_BYTES, 128'd25, w0(32'd110), '0, '0, '0, '0, 32'h0,
             128'd25 << 112, 1'b1, 3'd1, 32'h4, "shlqby14");
        step(SHIFT_LEFT_QUADWORD_BY_BYTES, 128'd25, w0(32'd16), '0, '0, '0, '0, 32'h0,
             128'd0, 1'b1, 3'd1, 32'h4, "shlqby16");
        step(SHIFT_LEFT_QUADWORD_BY_BYTE_IMMEDIATE, 128'hFFFF, '0, '0, 7'd2, '0, '0, 32'h0,
             128'hFFFF_0000, 1'b1, 3'd1, 32'h4, "shlqbyi");
        step(SHIFT_LEFT_QUADWORD_BY_BYTES_FROM_BIT_SHIFT_COUNT, 128'd1, w0(32'd16), '0, '0, '0, '0,
             32'h0, 128'd65536, 1'b1, 3'd1, 32'h4, "shlqbybi");
        step(ROTATE_QUADWORD_BY_BITS, 128'd75, w0(32'd61), '0, '0, '0, '0, 32'h0,
             128'd2400, 1'b1, 3'd1, 32'h4, "rotqbi");
        step(ROTATE_QUADWORD_BY_BITS_IMMEDIATE, 128'd1 << 127, '0, '0, 7'd1, '0, '0, 32'h0,
             128'd1, 1'b1, 3'd1, 32'h4, "rotqbii_wrap");
        step(ROTATE_QUADWORD_BY_BYTES, 128'd1 << 120, w0(32'd1), '0, '0, '0, '0, 32'h0,
             128'd1, 1'b1, 3'd1, 32'h4, "rotqby_wrap");
        step(ROTATE_QUADWORD_BY_BYTES_IMMEDIATE, 128'hFF, '0, '0, 7'd15, '0, '0, 32'h0,
             128'hFF << 120, 1'b1, 3'd1, 32'h4, "rotqbyi15");
        step(ROTATE_QUADWORD_BY_BYTES_FROM_BIT_SHIFT_COUNT, 128'hAB << 120, w0(32'd8), '0, '0, '0,
             '0, 32'h0, 128'hAB, 1'b1, 3'd1, 32'h4, "rotqbybi");

        // gather ops: real results when enabled, NOP record otherwise
`ifdef ODD_PIPE_GATHER_EN
        g_b = {32'h1, 96'd0}; g_h = {32'h80, 96'd0}; g_w = {32'h1, 96'd0};
        g_wr = 1'b1; g_u = 3'd1;
`else
        g_b = '0; g_h = '0; g_w = '0;
        g_wr = 1'b0; g_u = 3'd0;
`endif
        step(GATHER_BITS_FROM_BYTES, 128'd15, '0, '0, '0, '0, '0, 32'h0,
             g_b, g_wr, g_u, 32'h4, "gbb");
        step(GATHER_BITS_FROM_HALFWORDS, {16'h0001, 112'd0}, '0, '0, '0, '0, '0, 32'h0,
             g_h, g_wr, g_u, 32'h4, "gbh");
        step(GATHER_BITS_FROM_WORDS, 128'd45, '0, '0, '0, '0, '0, 32'h0,
             g_w, g_wr, g_u, 32'h4, "gb");

        // local-store class
        step(STORE_QUADWORD_D_FORM, w0(32'h100), '0, LS_X, '0, 10'd2, '0, 32'h0,
             128'd0, 1'b0, 3'd2, 32'h4, "stqd");
        chk("stqd_addr", 143'(ls_addr), 143'(15'h0120));
        chk("stqd_data", 143'(ls_dout), 143'(LS_X));
        step(LOAD_QUADWORD_D_FORM, w0(32'h100), '0, '0, '0, 10'd2, '0, 32'h0,
             LS_X, 1'b1, 3'd2, 32'h4, "lqd");
        chk("lqd_addr", 143'(ls_addr), 143'(15'h0120));
        step(LOAD_QUADWORD_A_FORM, '0, '0, '0, '0, '0, 16'hFFFF, 32'h0,
             LS_X, 1'b1, 3'd2, 32'h4, "lqa_neg");
        chk("lqa_neg_addr", 143'(ls_addr), 143'(15'h7FF0));
        step(LOAD_QUADWORD_A_FORM, '0, '0, '0, '0, '0, 16'h0010, 32'h0,
             LS_X, 1'b1, 3'd2, 32'h4, "lqa");
        chk("lqa_addr", 143'(ls_addr), 143'(15'h0040));

        // branch class
        step(BRANCH_IF_ZERO_WORD, '0, '0, {32'd0, {96{1'b1}}}, '0, '0, 16'd4, 32'h40,
             128'd0, 1'b0, 3'd3, 32'h50, "brz_taken");
        step(BRANCH_IF_ZERO_WORD, '0, '0, w0(32'd1), '0, '0, 16'd4, 32'h40,
             128'd0, 1'b0, 3'd3, 32'h44, "brz_not");
        step(BRANCH_IF_NOT_ZERO_WORD, '0, '0, w0(32'd5), '0, '0, 16'd4, 32'h40,
             128'd0, 1'b0, 3'd3, 32'h50, "brnz_taken");
        step(BRANCH_RELATIVE, '0, '0, '0, '0, '0, 16'hFFFE, 32'h100,
             128'd0, 1'b0, 3'd3, 32'hF8, "br_neg");
        step(BRANCH_ABSOLUTE, '0, '0, '0, '0, '0, 16'h0100, 32'h1234,
             128'd0, 1'b0, 3'd3, 32'h400, "bra");
        step(BRANCH_RELATIVE_AND_SET_LINK, '0, '0, '0, '0, '0, 16'd2, 32'h200,
             {32'h204, 96'd0}, 1'b1, 3'd3, 32'h208, "brsl");

        // reset mid-flight, with a branch presented on the same edge
        op = BRANCH_RELATIVE_AND_SET_LINK; pc_in = 32'h300; i16 = 16'd8;
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("midrst_out", out_op, '0);
        chk("midrst_pc", 143'(pc_out), '0);
        chk("midrst_wen", 143'(ls_wen), '0);
        reset = 1'b0;
        prefill();

        // other / unknown opcodes; the queued zeros confirm in-flight work was discarded
        step(NOP, 128'd7, '0, '0, '0, '0, '0, 32'h10,
             128'd0, 1'b0, 3'd0, 32'h14, "nop");
        step(op_code_e'(5'd31), 128'd7, '0, '0, '0, '0, '0, 32'h13,
             128'd0, 1'b0, 3'd0, 32'h14, "unknown");
        step(NOP, '0, '0, '0, '0, '0, '0, 32'h0, 128'd0, 1'b0, 3'd0, 32'h4, "drain0");
        step(NOP, '0, '0, '0, '0, '0, '0, 32'h0, 128'd0, 1'b0, 3'd0, 32'h4, "drain1");
        step(NOP, '0, '0, '0, '0, '0, '0, 32'h0, 128'd0, 1'b0, 3'd0, 32'h4, "drain2");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
